// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences one compute run, pulsing set/clr for a set-priority running flag and counting beats.
module core_run_ctrl #(
  parameter int CountBits = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 srst_i,
  input  logic                 start_i,
  input  logic [CountBits-1:0] len_i,
  input  logic                 beat_i,
  input  logic                 abort_i,
  output logic                 set_o,
  output logic                 clr_o,
  output logic                 busy_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic                 start_err_o,
  output logic [CountBits-1:0] count_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CountBits-1:0] One = 1;
  state_t state_q, state_d;
  logic [CountBits-1:0] len_q, len_d, count_q, count_d;
  logic set_q, set_d, clr_q, clr_d, done_q, done_d, aborted_q, aborted_d, err_q, err_d;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    count_d = count_q;
    set_d = 1'b0;
    clr_d = 1'b0;
    done_d = 1'b0;
    aborted_d = 1'b0;
    err_d = 1'b0;
    if (state_q == RUN) begin
      err_d = start_i;
      if (abort_i) begin
        state_d = IDLE;
        aborted_d = 1'b1;
        clr_d = 1'b1;
      end else if (beat_i) begin
        count_d = count_q + One;
        if (count_q == len_q - One) begin
          state_d = DONE;
          done_d = 1'b1;
          clr_d = 1'b1;
        end
      end
    end else if (start_i) begin
      // a zero-length run completes immediately without ever touching the flag
      len_d = len_i;
      count_d = '0;
      state_d = (len_i != '0) ? RUN : DONE;
      set_d = len_i != '0;
      done_d = len_i == '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q <= '0;
      count_q <= '0;
      {set_q, clr_q, done_q, aborted_q, err_q} <= '0;
    end else if (srst_i) begin
      state_q <= IDLE;
      len_q <= '0;
      count_q <= '0;
      {set_q, clr_q, done_q, aborted_q, err_q} <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      count_q <= count_d;
      {set_q, clr_q, done_q, aborted_q, err_q} <= {set_d, clr_d, done_d, aborted_d, err_d};
    end
  end
  assign set_o = set_q;
  assign clr_o = clr_q;
  assign busy_o = state_q == RUN;
  assign last_o = (state_q == RUN) && (count_q == len_q - One);
  assign done_o = done_q;
  assign aborted_o = aborted_q;
  assign start_err_o = err_q;
  assign count_o = count_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed checks of run start, counting, completion, abort, start error and resets.
module tb_core_run_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1, srst_i = 1'b0, start_i = 1'b0, beat_i = 1'b0, abort_i = 1'b0;
  logic [15:0] len_i = '0, count_o;
  logic set_o, clr_o, busy_o, last_o, done_o, aborted_o, start_err_o;
  logic [6:0] flags;
  int total = 0, bad = 0;
  core_run_ctrl #(.CountBits(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .srst_i(srst_i), .start_i(start_i), .len_i(len_i),
    .beat_i(beat_i), .abort_i(abort_i), .set_o(set_o), .clr_o(clr_o), .busy_o(busy_o),
    .last_o(last_o), .done_o(done_o), .aborted_o(aborted_o), .start_err_o(start_err_o),
    .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  // flag order: set clr busy last done aborted start_err
  assign flags = {set_o, clr_o, busy_o, last_o, done_o, aborted_o, start_err_o};
  task automatic cyc(input logic s, input logic [15:0] l, input logic b, input logic a);
    start_i = s;
    len_i = l;
    beat_i = b;
    abort_i = a;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    beat_i = 1'b0;
    abort_i = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [6:0] ef, input logic [15:0] ec);
    total++;
    assert (flags === ef) else begin
      bad++;
      $error("FAIL %s flags got=%b exp=%b", tag, flags, ef);
    end
    total++;
    assert (count_o === ec) else begin
      bad++;
      $error("FAIL %s count got=%0d exp=%0d", tag, count_o, ec);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset", 7'b0000000, 0);
    rst_i = 1'b0;
    cyc(0, 0, 0, 0); chk("idle", 7'b0000000, 0);
    cyc(1, 3, 1, 0); chk("l3_start", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("l3_b1", 7'b0010000, 1);
    cyc(0, 0, 1, 0); chk("l3_b2", 7'b0011000, 2);
    cyc(0, 0, 1, 0); chk("l3_done", 7'b0100100, 3);
    cyc(0, 0, 0, 0); chk("l3_idle", 7'b0000000, 3);
    cyc(1, 4, 0, 0); chk("l4_start", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("l4_b1", 7'b0010000, 1);
    cyc(0, 0, 0, 0); chk("l4_g1", 7'b0010000, 1);
    cyc(0, 0, 1, 0); chk("l4_b2", 7'b0010000, 2);
    cyc(0, 0, 0, 0); chk("l4_g2", 7'b0010000, 2);
    cyc(0, 0, 1, 0); chk("l4_b3", 7'b0011000, 3);
    cyc(0, 0, 0, 0); chk("l4_g3", 7'b0011000, 3);
    cyc(0, 0, 1, 0); chk("l4_done", 7'b0100100, 4);
    cyc(0, 0, 0, 0); chk("l4_idle1", 7'b0000000, 4);
    cyc(0, 0, 0, 0); chk("l4_idle2", 7'b0000000, 4);
    cyc(1, 0, 1, 0); chk("l0_done", 7'b0000100, 0);
    cyc(0, 0, 0, 0); chk("l0_idle", 7'b0000000, 0);
    cyc(1, 5, 0, 0); chk("ab2_start", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("ab2_b1", 7'b0010000, 1);
    cyc(0, 0, 1, 0); chk("ab2_b2", 7'b0010000, 2);
    cyc(0, 0, 1, 1); chk("ab2_abort", 7'b0100010, 2);
    cyc(0, 0, 0, 0); chk("ab2_idle", 7'b0000000, 2);
    cyc(1, 5, 0, 0); chk("ab5_start", 7'b1010000, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, 0); chk("ab5_beat", (i == 4) ? 7'b0011000 : 7'b0010000, 16'(i));
    end
    cyc(0, 0, 1, 1); chk("ab5_abort", 7'b0100010, 4);
    cyc(0, 0, 0, 0); chk("ab5_idle", 7'b0000000, 4);
    cyc(1, 3, 0, 0); chk("se_start", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("se_b1", 7'b0010000, 1);
    cyc(1, 7, 1, 0); chk("se_err", 7'b0011001, 2);
    cyc(0, 0, 1, 0); chk("se_done", 7'b0100100, 3);
    cyc(1, 2, 0, 0); chk("b2b_start", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("b2b_b1", 7'b0011000, 1);
    cyc(0, 0, 1, 0); chk("b2b_done", 7'b0100100, 2);
    cyc(0, 0, 0, 0); chk("b2b_idle", 7'b0000000, 2);
    cyc(1, 8, 0, 0); chk("rst_start", 7'b1010000, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 0); chk("rst_beat", 7'b0010000, 16'(i));
    end
    #2 rst_i = 1'b1;
    #1 chk("rst_async", 7'b0000000, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    cyc(0, 0, 1, 0); chk("rst_after", 7'b0000000, 0);
    cyc(1, 2, 0, 0); chk("rst_restart", 7'b1010000, 0);
    cyc(0, 0, 1, 0); chk("rst_rb1", 7'b0011000, 1);
    cyc(0, 0, 1, 0); chk("rst_rdone", 7'b0100100, 2);
    cyc(1, 8, 0, 0); chk("srst_start", 7'b1010000, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 1, 0); chk("srst_beat", 7'b0010000, 16'(i));
    end
    srst_i = 1'b1;
    cyc(0, 0, 1, 1); chk("srst_apply", 7'b0000000, 0);
    srst_i = 1'b0;
    cyc(0, 0, 0, 0); chk("srst_after", 7'b0000000, 0);
    cyc(1, 1, 0, 0); chk("l1_start", 7'b1011000, 0);
    cyc(0, 0, 1, 0); chk("l1_done", 7'b0100100, 1);
    cyc(0, 0, 0, 0); chk("l1_idle", 7'b0000000, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller that drives the set and clear inputs of a downstream set-priority SR running flag. It accepts a start request with a beat count and counts completed work beats. It emits a one-cycle set pulse at the start of a run and one-cycle clear and done pulses when the final beat completes. It also supports an abort path and sequences every compute pass in the design, for example one layer pass of the MNIST datapath.

## Interface
- CountBits, default 16, width of the length and beat counter; maximum run length is 2^CountBits-1.
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- srst_i  input  1  synchronous clear to IDLE, same effect as reset but sampled on the clock.
- start_i  input  1  start request, sampled only in IDLE or DONE.
- len_i  input  CountBits  run length in beats, sampled with start_i.
- beat_i  input  1  one work beat completed this cycle, counted only in RUN.
- abort_i  input  1  terminate the current run without done.
- set_o  output  1  one-cycle pulse to the running flag set input.
- clr_o  output  1  one-cycle pulse to the running flag synchronous reset input.
- busy_o  output  1  high while in RUN.
- last_o  output  1  high in RUN when the next beat is the final one.
- done_o  output  1  one-cycle pulse when a run completes normally.
- aborted_o  output  1  one-cycle pulse when a run is aborted.
- start_err_o  output  1  one-cycle pulse when start_i is asserted while in RUN.
- count_o  output  CountBits  beats completed in the current or most recent run.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset and srst_i both force IDLE and drive every output to 0, including count_o and the latched length. Neither produces a clr_o pulse.
- IDLE or DONE, start_i=1, len_i!=0:
  - Latch len_i and set count to 0.
  - Go to RUN, with set_o=1 for the first RUN cycle.
- IDLE or DONE, start_i=1, len_i==0:
  - Go to DONE with done_o=1 and count_o=0.
  - set_o, clr_o and busy_o are never asserted, so no run occurs.
- DONE with no start goes to IDLE after exactly one cycle.
- RUN:
  - Each cycle with beat_i=1 increments count.
  - When beat_i=1 and count==len-1, go to DONE with done_o=1, clr_o=1 and count_o=len.
- RUN, abort_i=1: go to IDLE with aborted_o=1, clr_o=1 and done_o=0. count_o holds the beats completed before the abort cycle; a beat in the abort cycle is not counted.
- Simultaneous final beat and abort_i: abort wins. aborted_o=1 and done_o=0.
- start_i while in RUN is ignored and produces start_err_o=1 for one cycle. If abort_i is asserted in the same cycle, abort still applies.
- set_o and clr_o are never both 1 in the same cycle, which keeps the downstream set-priority flag unambiguous.
- count_o holds its final value in IDLE and DONE until the next accepted start.
- count never wraps, because the transition at len-1 precedes overflow.

## Timing
- All outputs are registered, with no combinational input-to-output path except last_o. last_o is decoded from registered state and count only.
- A start sampled at edge k gives, after edge k:
  - busy_o=1 and set_o=1.
  - The first countable beat is at edge k+1; a beat at edge k is ignored.
- A final beat sampled at edge m gives:
  - after edge m: done_o=1, clr_o=1, busy_o=0;
  - after edge m+1: pulses low.
- Minimum run is len=1: set_o in cycle k+1, done_o/clr_o in cycle k+2 if beat_i is high at edge k+1.
- Back-to-back: a start sampled in DONE (edge m+1) gives set_o after m+1, so there is no idle cycle between runs.
- rst_i asserted mid-run immediately forces all outputs to 0. No done_o, aborted_o or clr_o pulse is produced.

## Test plan
- Reset, then start_i with len_i=3 and beat_i held high -> set_o in the cycle after start; count_o 1,2,3; done_o and clr_o one cycle after the third beat; busy_o high for exactly 3 cycles.
- len_i=4 with beats on alternate cycles -> last_o high only after count reaches 3; done_o follows the 4th beat; count_o=4 held in IDLE.
- len_i=0 -> done_o=1 one cycle later; set_o, clr_o and busy_o stay 0; count_o=0.
- len_i=5, abort_i after 2 beats, and separately abort_i coincident with the 5th beat -> aborted_o=1, clr_o=1, done_o=0, count_o=2 and 4 respectively.
- start_i during RUN -> start_err_o pulses, len unchanged, and the run completes with the original length. Then start_i in DONE with len_i=2 -> set_o on the next cycle with no IDLE gap.
- rst_i and, separately, srst_i asserted at count_o=3 of len_i=8 -> all outputs 0, no clr_o or done_o, state IDLE, and a new start is accepted afterwards.
